// File: rtl/seven_segment_scan_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex glyphs.
// No timing of its own.
// No flow control; constants only.
package seven_segment_scan_pkg;

  // Glyph bit order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_OFF_AL = 7'b1111111;
  localparam logic [6:0] SEG_0_AL   = 7'b1000000;
  localparam logic [6:0] SEG_1_AL   = 7'b1111001;
  localparam logic [6:0] SEG_2_AL   = 7'b0100100;
  localparam logic [6:0] SEG_3_AL   = 7'b0110000;
  localparam logic [6:0] SEG_4_AL   = 7'b0011001;
  localparam logic [6:0] SEG_5_AL   = 7'b0010010;
  localparam logic [6:0] SEG_6_AL   = 7'b0000010;
  localparam logic [6:0] SEG_7_AL   = 7'b1111000;
  localparam logic [6:0] SEG_8_AL   = 7'b0000000;
  localparam logic [6:0] SEG_9_AL   = 7'b0011000;
  localparam logic [6:0] SEG_A_AL   = 7'b0001000;
  localparam logic [6:0] SEG_B_AL   = 7'b0000011;
  localparam logic [6:0] SEG_C_AL   = 7'b1000110;
  localparam logic [6:0] SEG_D_AL   = 7'b0100001;
  localparam logic [6:0] SEG_E_AL   = 7'b0000110;
  localparam logic [6:0] SEG_F_AL   = 7'b0001110;

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// Hex nibble to active-low seven-segment glyph.
// Purely combinational, zero cycles.
// No flow control.
module seven_segment_hex_decoder
  import seven_segment_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Glyph lookup; the caller applies output polarity.
  always_comb begin
    pattern = SEG_OFF_AL;
    case (nibble)
      4'h0: pattern = SEG_0_AL;
      4'h1: pattern = SEG_1_AL;
      4'h2: pattern = SEG_2_AL;
      4'h3: pattern = SEG_3_AL;
      4'h4: pattern = SEG_4_AL;
      4'h5: pattern = SEG_5_AL;
      4'h6: pattern = SEG_6_AL;
      4'h7: pattern = SEG_7_AL;
      4'h8: pattern = SEG_8_AL;
      4'h9: pattern = SEG_9_AL;
      4'hA: pattern = SEG_A_AL;
      4'hB: pattern = SEG_B_AL;
      4'hC: pattern = SEG_C_AL;
      4'hD: pattern = SEG_D_AL;
      4'hE: pattern = SEG_E_AL;
      4'hF: pattern = SEG_F_AL;
      default: pattern = SEG_OFF_AL;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display driver with double-buffered value and anti-ghost blanking.
// Outputs registered one cycle after the slot counter / digit index / shadow change.
// No backpressure: a load is always accepted; the newest load before a frame wrap wins.
module seven_segment_scan
  import seven_segment_scan_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_CYCLES    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_sync
);

  localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                pending;
  logic [4*DIGITS-1:0] stg_value;
  logic [DIGITS-1:0]   stg_dp;
  logic [DIGITS-1:0]   stg_en;
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_en;

  logic slot_end;
  logic last_digit;
  logic wrap;

  assign slot_end   = (cnt == CNT_W'(SCAN_CYCLES - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign wrap       = slot_end && last_digit;

  // Slot counter and digit index; frame_sync marks the first cycle of a new frame.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt        <= '0;
      idx        <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= wrap;
      if (slot_end) begin
        cnt <= '0;
        idx <= last_digit ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Staging captures every load; shadow only changes at the frame wrap so a frame never tears.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pending   <= 1'b0;
      stg_value <= '0;
      stg_dp    <= '0;
      stg_en    <= '0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
    end else begin
      if (load) begin
        stg_value <= value;
        stg_dp    <= dp;
        stg_en    <= digit_en;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          sh_value <= value;
          sh_dp    <= dp;
          sh_en    <= digit_en;
        end else if (pending) begin
          sh_value <= stg_value;
          sh_dp    <= stg_dp;
          sh_en    <= stg_en;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  logic [3:0]        nib;
  logic [6:0]        pat_al;
  logic              upper_nz;
  logic              suppressed;
  logic              visible;
  logic [DIGITS-1:0] sel;

  assign nib = sh_value[{idx, 2'b00} +: 4];
  assign sel = DIGITS'(1) << idx;

  seven_segment_hex_decoder u_dec (
    .nibble  (nib),
    .pattern (pat_al)
  );

  // Visibility: past the blank window, enabled, and not a leading zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && sh_value[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    suppressed = (LZ_BLANK != 0) && (idx != '0) && !upper_nz;
    visible    = (int'(cnt) >= BLANK_CYCLES) && sh_en[idx] && !suppressed;
  end

  // Registered drive with polarity applied last; dark slots drive everything inactive.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      seven_segments <= (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
      dot            <= (SEG_ACTIVE_LOW != 0);
      anodes         <= (AN_ACTIVE_LOW != 0) ? '1 : '0;
    end else if (visible) begin
      seven_segments <= (SEG_ACTIVE_LOW != 0) ? pat_al : ~pat_al;
      dot            <= (SEG_ACTIVE_LOW != 0) ? ~sh_dp[idx] : sh_dp[idx];
      anodes         <= (AN_ACTIVE_LOW != 0) ? ~sel : sel;
    end else begin
      seven_segments <= (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
      dot            <= (SEG_ACTIVE_LOW != 0);
      anodes         <= (AN_ACTIVE_LOW != 0) ? '1 : '0;
    end
  end

endmodule
